// File: rtl/mc_decoder_pkg.sv
// mc_decoder_pkg
//   Shared definitions for the multi-cycle ARM control decoder:
//   - FSM state enumeration
//   - op / cmd field encodings
//   - datapath select encodings
package mc_decoder_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXECR  = 4'd6,
        ST_EXECI  = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9
    } state_t;

    // instr[27:26]
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder
//   Combinational data-processing decode: cmd/S -> ALU operation, flag
//   write enables and the compare (no register result) indication.
// Ports
//   cmd_i          instr[24:21]
//   s_i            instr[20] (S bit)
//   alu_control_o  ALU operation (EOR decoded only when ALU_CTRL_W >= 3)
//   flag_w_o       [1] NZ write, [0] CV write
//   no_write_o     compare: suppress register write-back
module mc_alu_decoder
    import mc_decoder_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 2
) (
    input  logic [3:0]            cmd_i,
    input  logic                  s_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic [1:0]            flag_w_o,
    output logic                  no_write_o
);

    logic arith;

    always_comb begin
        alu_control_o = '0;
        no_write_o    = 1'b0;
        arith         = 1'b0;
        case (cmd_i)
            CMD_ADD: arith = 1'b1;
            CMD_SUB: begin
                alu_control_o = ALU_CTRL_W'(2'b01);
                arith         = 1'b1;
            end
            CMD_AND: alu_control_o = ALU_CTRL_W'(2'b10);
            CMD_ORR: alu_control_o = ALU_CTRL_W'(2'b11);
            CMD_CMP: begin
                alu_control_o = ALU_CTRL_W'(2'b01);
                arith         = 1'b1;
                no_write_o    = 1'b1;
            end
            CMD_EOR: begin
                if (ALU_CTRL_W >= 3) alu_control_o = ALU_CTRL_W'(3'b100);
            end
            default: alu_control_o = '0;
        endcase
        // C/V only meaningful for arithmetic; N/Z follow S for everything
        flag_w_o = {s_i, s_i & arith};
    end

endmodule

// File: rtl/mc_decoder.sv
// mc_decoder
//   Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB for the shared-memory
//   multi-cycle ARM datapath. Outputs are combinational from state + IR.
// Configuration macro: MC_DECODER_MEM_READY_EN
//   defined   -> mem_ready port; FETCH/MEMRD/MEMWR wait for mem_ready=1
//   undefined -> single-cycle memory, one clock per state
// Ports
//   clk, reset_n          clock, async active-low reset
//   op, funct, rd         IR fields instr[27:26], [25:20], [15:12]
//   mem_ready             memory handshake (macro only)
//   pcs, next_pc          PC writes (branch/rd==15, PC+4)
//   reg_w, mem_w          register / memory write enables
//   ir_write, adr_src     IR load, memory address select
//   alu_src_a/b           ALU operand selects
//   result_src, imm_src   result mux / immediate-extend selects
//   reg_src               register address selects
//   alu_control, flag_w   ALU op, flag write enables
//   no_write, instr_done  compare indication, last-state pulse
//   state_o               current state (debug)
module mc_decoder
    import mc_decoder_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 2,
    parameter int unsigned STATE_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            rd,
`ifdef MC_DECODER_MEM_READY_EN
    input  logic                  mem_ready,
`endif
    output logic                  pcs,
    output logic                  next_pc,
    output logic                  reg_w,
    output logic                  mem_w,
    output logic                  ir_write,
    output logic                  adr_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            flag_w,
    output logic                  no_write,
    output logic                  instr_done,
    output logic [STATE_W-1:0]    state_o
);

    state_t                  state_q, state_d;
    logic                    mem_rdy;
    logic                    exec;
    logic [ALU_CTRL_W-1:0]   dec_alu;
    logic [1:0]              dec_flag_w;
    logic                    dec_no_write;

`ifdef MC_DECODER_MEM_READY_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .cmd_i         (funct[4:1]),
        .s_i           (funct[0]),
        .alu_control_o (dec_alu),
        .flag_w_o      (dec_flag_w),
        .no_write_o    (dec_no_write)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pcs         = 1'b0;
        next_pc     = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RD2;
        result_src  = RES_ALUOUT;
        instr_done  = 1'b0;
        exec        = 1'b0;
        case (state_q)
            ST_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write   = mem_rdy;
                next_pc    = mem_rdy;
                state_d    = mem_rdy ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                case (op)
                    OP_MEM:  state_d = ST_MEMADR;
                    OP_DP:   state_d = funct[5] ? ST_EXECI : ST_EXECR;
                    OP_BR:   state_d = ST_BRANCH;
                    default: begin
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                alu_src_b = SRCB_EXT;
                state_d   = funct[0] ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                adr_src = 1'b1;
                state_d = mem_rdy ? ST_MEMWB : ST_MEMRD;
            end
            ST_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
                pcs        = (rd == 4'hF);
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEMWR: begin
                // write strobe stays up for the whole wait; completion only on ready
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                instr_done = mem_rdy;
                state_d    = mem_rdy ? ST_FETCH : ST_MEMWR;
            end
            ST_EXECR, ST_EXECI: begin
                exec       = 1'b1;
                alu_src_b  = (state_q == ST_EXECI) ? SRCB_EXT : SRCB_RD2;
                instr_done = dec_no_write;
                state_d    = dec_no_write ? ST_FETCH : ST_ALUWB;
            end
            ST_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_w      = 1'b1;
                pcs        = (rd == 4'hF);
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_b  = SRCB_EXT;
                result_src = RES_ALURES;
                pcs        = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        alu_control = exec ? dec_alu      : '0;
        flag_w      = exec ? dec_flag_w   : 2'b00;
        no_write    = exec ? dec_no_write : 1'b0;
        imm_src     = op;
        reg_src     = {op == OP_MEM, op == OP_BR};

        // state register already reads FETCH during reset; force everything quiet
        if (!reset_n) begin
            pcs         = 1'b0;
            next_pc     = 1'b0;
            reg_w       = 1'b0;
            mem_w       = 1'b0;
            ir_write    = 1'b0;
            adr_src     = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = '0;
            result_src  = '0;
            imm_src     = '0;
            reg_src     = '0;
            alu_control = '0;
            flag_w      = '0;
            no_write    = 1'b0;
            instr_done  = 1'b0;
        end
    end

    assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_decoder.sv
`timescale 1ns/1ps
module tb_mc_decoder;
    import mc_decoder_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] op = 2'b00;
    logic [5:0] funct = 6'd0;
    logic [3:0] rd = 4'd0;
`ifdef MC_DECODER_MEM_READY_EN
    logic       mem_ready = 1'b1;
`endif

    logic       pcs, next_pc, reg_w, mem_w, ir_write, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, reg_src, alu_control, flag_w;
    logic       no_write, instr_done;
    logic [3:0] state_o;

    logic       d3_pcs, d3_next_pc, d3_reg_w, d3_mem_w, d3_ir_write, d3_adr_src, d3_alu_src_a;
    logic [1:0] d3_alu_src_b, d3_result_src, d3_imm_src, d3_reg_src, d3_flag_w;
    logic [2:0] d3_alu_control;
    logic       d3_no_write, d3_instr_done;
    logic [3:0] d3_state_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc_decoder #(.ALU_CTRL_W(2), .STATE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .rd(rd),
`ifdef MC_DECODER_MEM_READY_EN
        .mem_ready(mem_ready),
`endif
        .pcs(pcs), .next_pc(next_pc), .reg_w(reg_w), .mem_w(mem_w), .ir_write(ir_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src),
        .alu_control(alu_control), .flag_w(flag_w), .no_write(no_write),
        .instr_done(instr_done), .state_o(state_o)
    );

    mc_decoder #(.ALU_CTRL_W(3), .STATE_W(4)) dut3 (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .rd(rd),
`ifdef MC_DECODER_MEM_READY_EN
        .mem_ready(mem_ready),
`endif
        .pcs(d3_pcs), .next_pc(d3_next_pc), .reg_w(d3_reg_w), .mem_w(d3_mem_w),
        .ir_write(d3_ir_write), .adr_src(d3_adr_src), .alu_src_a(d3_alu_src_a),
        .alu_src_b(d3_alu_src_b), .result_src(d3_result_src), .imm_src(d3_imm_src),
        .reg_src(d3_reg_src), .alu_control(d3_alu_control), .flag_w(d3_flag_w),
        .no_write(d3_no_write), .instr_done(d3_instr_done), .state_o(d3_state_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       ir, npc, regw, memw, pcs, done, adr, srca;
        logic [1:0] srcb, res, imm, rsrc, alu;
        logic [2:0] alu3;
        logic [1:0] flagw;
        logic       nw;
        logic [3:0] st3;
    } obs_t;

    obs_t seq[$];

    function automatic obs_t sample();
        obs_t a;
        a.st = state_o;     a.ir = ir_write;   a.npc = next_pc;  a.regw = reg_w;
        a.memw = mem_w;     a.pcs = pcs;       a.done = instr_done;
        a.adr = adr_src;    a.srca = alu_src_a; a.srcb = alu_src_b;
        a.res = result_src; a.imm = imm_src;   a.rsrc = reg_src;
        a.alu = alu_control; a.alu3 = d3_alu_control; a.flagw = flag_w;
        a.nw = no_write;    a.st3 = d3_state_o;
        return a;
    endfunction

    function automatic obs_t phase(state_t s, logic [1:0] o);
        obs_t e = '0;
        e.st   = s;
        e.st3  = s;
        e.imm  = o;
        e.rsrc = {o == 2'b01, o == 2'b10};
        return e;
    endfunction

    // Expected per-cycle behaviour of one instruction, derived from its class.
    task automatic build(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
        obs_t e;
        logic [3:0] cmd;
        logic s, arith, cmp;
        seq.delete();
        e = phase(ST_FETCH, o);
        e.ir = 1; e.npc = 1; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
        seq.push_back(e);
        e = phase(ST_DECODE, o);
        e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; e.done = (o == 2'b11);
        seq.push_back(e);
        if (o == 2'b01) begin
            e = phase(ST_MEMADR, o); e.srcb = 2'b01;
            seq.push_back(e);
            if (f[0]) begin
                e = phase(ST_MEMRD, o); e.adr = 1;
                seq.push_back(e);
                e = phase(ST_MEMWB, o); e.res = 2'b01; e.regw = 1; e.done = 1; e.pcs = (r == 4'd15);
                seq.push_back(e);
            end else begin
                e = phase(ST_MEMWR, o); e.adr = 1; e.memw = 1; e.done = 1;
                seq.push_back(e);
            end
        end else if (o == 2'b10) begin
            e = phase(ST_BRANCH, o); e.srcb = 2'b01; e.res = 2'b10; e.pcs = 1; e.done = 1;
            seq.push_back(e);
        end else if (o == 2'b00) begin
            cmd = f[4:1]; s = f[0];
            e = phase(f[5] ? ST_EXECI : ST_EXECR, o);
            e.srcb = f[5] ? 2'b01 : 2'b00;
            arith = 0; cmp = 0;
            if (cmd == 4'd4)       begin e.alu = 0; e.alu3 = 0; arith = 1; end
            else if (cmd == 4'd2)  begin e.alu = 1; e.alu3 = 1; arith = 1; end
            else if (cmd == 4'd0)  begin e.alu = 2; e.alu3 = 2; end
            else if (cmd == 4'd12) begin e.alu = 3; e.alu3 = 3; end
            else if (cmd == 4'd10) begin e.alu = 1; e.alu3 = 1; arith = 1; cmp = 1; end
            else if (cmd == 4'd1)  begin e.alu = 0; e.alu3 = 4; end
            e.flagw = {s, s & arith};
            e.nw = cmp; e.done = cmp;
            seq.push_back(e);
            if (!cmp) begin
                e = phase(ST_ALUWB, o); e.regw = 1; e.done = 1; e.pcs = (r == 4'd15);
                seq.push_back(e);
            end
        end
    endtask

    // Caller is between edges with the DUT in FETCH.
    task automatic run_instr(input string name, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input int max_steps);
        obs_t a;
        op = o; funct = f; rd = r;
        build(o, f, r);
        #1;
        for (int i = 0; i < seq.size() && i < max_steps; i++) begin
            a = sample();
            tests++;
            if (a !== seq[i]) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, a, seq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        obs_t a, e;
        #12;
        e = '0; e.st = ST_FETCH; e.st3 = ST_FETCH;
        a = sample();
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL reset_quiet: got %h expected %h", a, e);
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_directed();
        run_instr("add_r", 2'b00, 6'b001000, 4'd1, 99);
        run_instr("cmp_imm", 2'b00, 6'b110101, 4'd0, 99);
        run_instr("ldr_pc", 2'b01, 6'b011001, 4'd15, 99);
        run_instr("str", 2'b01, 6'b011000, 4'd3, 99);
        run_instr("branch", 2'b10, 6'b101010, 4'd7, 99);
        run_instr("undef", 2'b11, 6'b000000, 4'd2, 99);
        run_instr("eor_s", 2'b00, 6'b000011, 4'd15, 99);
        run_instr("orr_alu_pc", 2'b00, 6'b111001, 4'd15, 99);
    endtask

    task automatic test_reset_mid();
        obs_t a, e;
        run_instr("ldr_abort", 2'b01, 6'b011001, 4'd5, 3);
        #2 reset_n = 1'b0;
        #1;
        e = '0; e.st = ST_FETCH; e.st3 = ST_FETCH;
        a = sample();
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL reset_mid: got %h expected %h", a, e);
        end
        @(negedge clk); reset_n = 1'b1;
        run_instr("after_reset", 2'b11, 6'b000000, 4'd0, 99);
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [5:0] f;
        logic [3:0] r;
        logic [3:0] cmds [8];
        cmds = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd10, 4'd12, 4'd7, 4'd15};
        for (int n = 0; n < 60; n++) begin
            o = 2'($urandom_range(0, 3));
            f = 6'($urandom);
            if ($urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 7)];
            r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_instr("random", o, f, r, 99);
        end
    endtask

`ifdef MC_DECODER_MEM_READY_EN
    task automatic test_mem_ready();
        obs_t a;
        op = 2'b00; funct = 6'b001000; rd = 4'd1;
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            a = sample();
            tests++;
            if (a.st !== ST_FETCH || a.ir !== 1'b0 || a.npc !== 1'b0) begin
                fails++;
                $display("FAIL fetch_wait %0d: got st=%0d ir=%b npc=%b expected st=0 ir=0 npc=0",
                         i, a.st, a.ir, a.npc);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        run_instr("fetch_ready", 2'b00, 6'b001000, 4'd1, 99);
    endtask
`endif

    task automatic test_final_state();
        tests++;
        if (state_o !== 4'(ST_FETCH)) begin
            fails++;
            $display("FAIL final_state: got %0d expected %0d", state_o, ST_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
`ifdef MC_DECODER_MEM_READY_EN
        test_mem_ready();
`endif
        test_final_state();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
